// File: rtl/fetch_req_issuer.sv
// Fetch request initiator: walks the fetch PC one group at a time and issues
// double-word-aligned icache requests tagged with id and generation.
module fetch_req_issuer #(
  parameter int                     VADDR_WIDTH  = 39,
  parameter int                     NUM_OF_FETCH = 4,
  parameter int                     DW_SIZE      = 8,
  parameter logic [VADDR_WIDTH-1:0] RESET_VECTOR = VADDR_WIDTH'(32'h1000)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_valid,
  input  logic [VADDR_WIDTH-1:0] flush_addr,
  input  logic                   pred_redirect_valid,
  input  logic [VADDR_WIDTH-1:0] pred_redirect_addr,
  input  logic                   stall_in,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [VADDR_WIDTH-1:0] req_vaddr_dw_aligned,
  output logic [31:0]            req_id,
  output logic [31:0]            req_generation,
  output logic                   grp_valid,
  output logic [VADDR_WIDTH-1:0] grp_first_vaddr,
  output logic [31:0]            grp_first_id,
  output logic [31:0]            generation
);

  localparam int                     GRP_BYTES = NUM_OF_FETCH * 4;
  localparam logic [VADDR_WIDTH-1:0] DW_MASK   = ~(VADDR_WIDTH'(DW_SIZE - 1));
  localparam logic [VADDR_WIDTH-1:0] INSN_MASK = ~(VADDR_WIDTH'(3));

  typedef enum logic {
    ST_START = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                 r_state;
  logic [VADDR_WIDTH-1:0] r_pc;
  logic [VADDR_WIDTH-1:0] r_dw_ptr;
  logic [VADDR_WIDTH-1:0] r_grp_first_vaddr;
  logic [31:0]            r_id_ctr;
  logic [31:0]            r_req_id;
  logic [31:0]            r_gen;
  logic [31:0]            r_req_gen;
  logic [31:0]            r_grp_first_id;
  logic [1:0]             r_rem;
  logic                   r_first;
  logic                   r_req_valid;
  logic                   r_grp_valid;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_grp_done;
  logic                   w_start;
  logic                   w_grp_pulse;
  logic [VADDR_WIDTH-1:0] w_npc;
  logic [VADDR_WIDTH-1:0] w_first_dw;
  logic [31:0]            w_nid;
  logic [31:0]            w_ngen;
  logic [1:0]             w_k;

  // Next group base (pc, id, gen) and whether a new group may be launched this edge.
  always_comb begin
    w_accept    = r_req_valid & req_ready;
    w_last      = w_accept & (r_rem == 2'd1);
    w_grp_pulse = w_accept & r_first & ~flush_valid;
    if (flush_valid) begin
      w_npc      = flush_addr & INSN_MASK;
      w_nid      = r_id_ctr + 32'd4;
      w_ngen     = r_gen + 32'd1;
      w_grp_done = 1'b1;
    end else if (pred_redirect_valid) begin
      w_npc      = pred_redirect_addr & INSN_MASK;
      w_nid      = r_id_ctr + 32'd4;
      w_ngen     = r_gen;
      w_grp_done = 1'b1;
    end else if (w_last) begin
      w_npc      = r_pc + VADDR_WIDTH'(GRP_BYTES);
      w_nid      = r_id_ctr + 32'd4;
      w_ngen     = r_gen;
      w_grp_done = 1'b1;
    end else begin
      w_npc      = r_pc;
      w_nid      = r_id_ctr;
      w_ngen     = r_gen;
      w_grp_done = (r_state == ST_START);
    end
    w_start    = w_grp_done & ~stall_in;
    // A group starting in the upper half of a double word spills into a third one.
    w_k        = w_npc[2] ? 2'd3 : 2'd2;
    w_first_dw = w_npc & DW_MASK;
  end

  // Group/request FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= ST_START;
      r_pc              <= RESET_VECTOR;
      r_id_ctr          <= 32'd0;
      r_gen             <= 32'd0;
      r_rem             <= 2'd0;
      r_first           <= 1'b0;
      r_dw_ptr          <= '0;
      r_req_id          <= 32'd0;
      r_req_gen         <= 32'd0;
      r_req_valid       <= 1'b0;
      r_grp_valid       <= 1'b0;
      r_grp_first_vaddr <= '0;
      r_grp_first_id    <= 32'd0;
    end else begin
      r_grp_valid <= w_grp_pulse;
      if (w_grp_pulse) begin
        r_grp_first_vaddr <= r_pc;
        r_grp_first_id    <= r_id_ctr;
      end
      r_pc     <= w_npc;
      r_id_ctr <= w_nid;
      r_gen    <= w_ngen;
      if (w_start) begin
        r_state     <= ST_ISSUE;
        r_dw_ptr    <= w_first_dw;
        r_req_id    <= w_nid;
        r_req_gen   <= w_ngen;
        r_rem       <= w_k;
        r_first     <= 1'b1;
        r_req_valid <= 1'b1;
      end else if (w_grp_done) begin
        r_state     <= ST_START;
        r_rem       <= 2'd0;
        r_first     <= 1'b0;
        r_req_valid <= 1'b0;
      end else if (w_accept) begin
        r_dw_ptr <= r_dw_ptr + VADDR_WIDTH'(DW_SIZE);
        r_req_id <= r_req_id + 32'd1;
        r_rem    <= r_rem - 2'd1;
        r_first  <= 1'b0;
      end
    end
  end

  assign req_valid            = r_req_valid;
  assign req_vaddr_dw_aligned = r_dw_ptr;
  assign req_id               = r_req_id;
  assign req_generation       = r_req_gen;
  assign grp_valid            = r_grp_valid;
  assign grp_first_vaddr      = r_grp_first_vaddr;
  assign grp_first_id         = r_grp_first_id;
  assign generation           = r_gen;

endmodule

// File: tb/tb_fetch_req_issuer.sv
// Bench for fetch_req_issuer: directed scenarios plus random traffic, checked
// against a queue-based model of the expected request stream.
module tb_fetch_req_issuer;

  localparam int VA = 39;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush_valid = 1'b0;
  logic [VA-1:0] flush_addr = '0;
  logic          pred_redirect_valid = 1'b0;
  logic [VA-1:0] pred_redirect_addr = '0;
  logic          stall_in = 1'b0;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic [VA-1:0] req_vaddr_dw_aligned;
  logic [31:0]   req_id;
  logic [31:0]   req_generation;
  logic          grp_valid;
  logic [VA-1:0] grp_first_vaddr;
  logic [31:0]   grp_first_id;
  logic [31:0]   generation;

  fetch_req_issuer #(
    .VADDR_WIDTH (VA),
    .NUM_OF_FETCH(4),
    .DW_SIZE     (8),
    .RESET_VECTOR(VA'(32'h1000))
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .flush_valid         (flush_valid),
    .flush_addr          (flush_addr),
    .pred_redirect_valid (pred_redirect_valid),
    .pred_redirect_addr  (pred_redirect_addr),
    .stall_in            (stall_in),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_vaddr_dw_aligned(req_vaddr_dw_aligned),
    .req_id              (req_id),
    .req_generation      (req_generation),
    .grp_valid           (grp_valid),
    .grp_first_vaddr     (grp_first_vaddr),
    .grp_first_id        (grp_first_id),
    .generation          (generation)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [VA-1:0] addr;
    logic [31:0]   id;
    logic          first;
  } req_t;

  // Model: remaining requests of the current group, in issue order.
  req_t          q[$];
  logic [VA-1:0] m_pc;
  logic [31:0]   m_idc;
  logic [31:0]   m_gen;
  logic          m_grp;
  logic [VA-1:0] m_gva;
  logic [31:0]   m_gid;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = VA'(32'h1000);
    m_idc = 32'd0;
    m_gen = 32'd0;
    m_grp = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    logic          acc;
    logic [31:0]   old_id;
    logic [VA-1:0] first_blk;
    logic [VA-1:0] last_blk;
    m_grp  = 1'b0;
    acc    = (q.size() > 0) && req_ready;
    old_id = m_idc;
    if (acc && !flush_valid) begin
      if (q[0].first) begin
        m_grp = 1'b1;
        m_gva = m_pc;
        m_gid = m_idc;
      end
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_pc  = m_pc + VA'(16);
        m_idc = m_idc + 32'd4;
      end
    end
    if (flush_valid) begin
      m_gen = m_gen + 32'd1;
      m_pc  = flush_addr & ~VA'(3);
      m_idc = old_id + 32'd4;
      q.delete();
    end else if (pred_redirect_valid) begin
      m_pc  = pred_redirect_addr & ~VA'(3);
      m_idc = old_id + 32'd4;
      q.delete();
    end
    if (q.size() == 0 && !stall_in) begin
      // One request per 8-byte block touched by the 16 bytes pc..pc+15.
      first_blk = m_pc >> 3;
      last_blk  = (m_pc + VA'(15)) >> 3;
      for (int j = 0; j <= int'(last_blk - first_blk); j++) begin
        q.push_back(req_t'{addr: (first_blk + VA'(j)) << 3, id: m_idc + 32'(j), first: (j == 0)});
      end
    end
  endtask

  task automatic compare_outputs();
    chk("req_valid", 64'(req_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("req_vaddr", 64'(req_vaddr_dw_aligned), 64'(q[0].addr));
      chk("req_id", 64'(req_id), 64'(q[0].id));
      chk("req_generation", 64'(req_generation), 64'(m_gen));
    end
    chk("generation", 64'(generation), 64'(m_gen));
    chk("grp_valid", 64'(grp_valid), 64'(m_grp));
    if (m_grp) begin
      chk("grp_first_vaddr", 64'(grp_first_vaddr), 64'(m_gva));
      chk("grp_first_id", 64'(grp_first_id), 64'(m_gid));
    end
  endtask

  task automatic cycle(input logic f, input logic [VA-1:0] fa, input logic p,
                       input logic [VA-1:0] pa, input logic st, input logic rdy);
    flush_valid         = f;
    flush_addr          = fa;
    pred_redirect_valid = p;
    pred_redirect_addr  = pa;
    stall_in            = st;
    req_ready           = rdy;
    @(posedge clock);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, "_grp_valid"}, 64'(grp_valid), 64'd0);
    chk({tag, "_req_vaddr"}, 64'(req_vaddr_dw_aligned), 64'd0);
    chk({tag, "_req_id"}, 64'(req_id), 64'd0);
    chk({tag, "_req_gen"}, 64'(req_generation), 64'd0);
    chk({tag, "_grp_vaddr"}, 64'(grp_first_vaddr), 64'd0);
    chk({tag, "_grp_id"}, 64'(grp_first_id), 64'd0);
    chk({tag, "_generation"}, 64'(generation), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Straight-line fetch from the reset vector.
    repeat (5) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    // Flush into the upper half of a double word.
    cycle(1'b1, VA'(32'h2006), 1'b0, '0, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    // Back-pressure on a request.
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    // Stall raised during a 3-DW group.
    cycle(1'b0, '0, 1'b1, VA'(32'h5004), 1'b0, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    // Flush and predicted redirect together.
    cycle(1'b1, VA'(32'h3000), 1'b1, VA'(32'h4000), 1'b0, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 3, VA'($urandom()), $urandom_range(99) < 6,
            VA'($urandom()), $urandom_range(99) < 20, $urandom_range(99) < 70);
    end

    // Asynchronous reset in the middle of traffic.
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (8) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
